and_input_debouncer: RTL
========================

Name: and_input_debouncer

Overview:
- Two-channel input conditioner placed directly upstream of the 2-input AND gate.
- Each raw, asynchronous input (A_RAW, B_RAW) passes through a synchronizer and then a counter-based debouncer.
- The clean levels A_DB and B_DB drive the gate's A and B pins.
- One-cycle change strobes are provided per channel for downstream logging.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per channel; legal range ≥2.
- DB_CYCLES, 4: consecutive mismatching samples required before the output flips; legal range ≥1.
- GLITCH_W, 8: width of the glitch counter; used only when the optional feature is enabled.

Ports:
- CLK  in  1  single clock domain.
- RST  in  1  synchronous, active-high reset.
- A_RAW  in  1  asynchronous raw input, channel A.
- B_RAW  in  1  asynchronous raw input, channel B.
- A_DB  out  1  debounced level; feeds AND gate pin A.
- B_DB  out  1  debounced level; feeds AND gate pin B.
- A_CHG  out  1  one-cycle pulse in the same cycle A_DB changes.
- B_CHG  out  1  one-cycle pulse in the same cycle B_DB changes.
- GLITCH_CNT  out  GLITCH_W  saturating count of aborted transitions; present only with the macro.

Behaviour:
- Interface: one clock, CLK. Reset is RST, synchronous and active-high.
- Reset: RST is sampled on the CLK rising edge and dominates all other logic. It clears:
  - all sync flops to 0;
  - both FSMs to STABLE;
  - counters to 0;
  - A_DB, B_DB, A_CHG, B_CHG to 0;
  - GLITCH_CNT to 0.
- Reset mid-count aborts the count with no CHG pulse and no glitch increment.
- Synchronizer: RAW passes through SYNC_STAGES flops; the last stage is s. All outputs are registered.
- Per-channel FSM, states STABLE and COUNT; cnt width is $clog2(DB_CYCLES+1).
  - STABLE, s==DB: hold.
  - STABLE, s!=DB, DB_CYCLES==1: DB<=s, CHG<=1, stay in STABLE.
  - STABLE, s!=DB, DB_CYCLES>1: go to COUNT, cnt<=1.
  - COUNT, s==DB: glitch. Go to STABLE, cnt<=0, DB unchanged, no CHG.
  - COUNT, s!=DB, cnt+1==DB_CYCLES: DB<=s, CHG<=1, go to STABLE, cnt<=0.
  - COUNT, s!=DB, otherwise: cnt<=cnt+1.
- CHG is high for exactly one cycle per DB transition and is 0 in every other cycle.
- Latency: RAW changes before edge 1 and stays stable. DB and CHG update at edge SYNC_STAGES+DB_CYCLES (edge 6 with defaults).
- Minimum accepted pulse width is DB_CYCLES cycles after synchronization. A shorter pulse produces no output change.
- Channels are fully independent. Simultaneous transitions on both channels update on the same edge, with no arbitration.
- If RAW is held at 1 through reset, DB rises SYNC_STAGES+DB_CYCLES edges after RST deasserts, with a CHG pulse.

Optional Feature:
- Macro: AND_INPUT_DEBOUNCER_GLITCH_CNT_EN.
- Defined:
  - GLITCH_CNT port and register exist.
  - The register increments by the number of channels that take the COUNT→STABLE glitch path in that cycle (0, 1 or 2).
  - It saturates at all-ones and never wraps; a +2 step from all-ones minus 1 also saturates.
- Undefined:
  - The port and register are absent.
  - Debounce behaviour and timing are identical to the defined case.

Decomposition:
- Shared package and_gate_pkg holds:
  - enum db_state_e {STABLE, COUNT};
  - default constants DEF_SYNC_STAGES=2 and DEF_DB_CYCLES=4.
- One sub-module, db_channel, implements the synchronizer, FSM and counter for one input.
  - Outputs: db, chg, glitch.
  - It is instantiated twice.
- The glitch counter and saturation logic live in the top module.

Test Plan:
1. Assert RST 2 cycles with RAW=0, then release → A_DB=B_DB=0, both CHG=0, GLITCH_CNT=0 for 20 cycles.
2. A_RAW 0→1 held → A_DB rises at edge 6 and A_CHG is high for that one cycle only; B_DB and B_CHG stay 0. Then A_RAW 1→0 → A_DB falls 6 edges later with a single pulse.
3. A_RAW high for 3 cycles, then back to 0 → A_DB stays 0, no A_CHG, GLITCH_CNT=1.
4. A_RAW and B_RAW rise on the same cycle → A_DB and B_DB rise on the same edge with both CHG pulses; a downstream AND_GATE instance shows Y=1 one delta later.
5. A_RAW held 1, RST asserted at edge 4 for 1 cycle → no CHG pulse; A_DB rises 6 edges after RST deasserts.
6. Build with GLITCH_W=2 and the macro defined; apply 5 three-cycle glitches on A and B simultaneously → GLITCH_CNT reads 3 and holds at 3.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared types and defaults for the AND-gate input conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package and_gate_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } db_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/db_channel.sv
// One input channel: synchronizer followed by a counter-based debouncer.
// Latency: db/chg update SYNC_STAGES+DB_CYCLES edges after a stable raw change.
// Backpressure: none; raw is sampled every cycle.
module db_channel
  import and_gate_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic chg,
  output logic glitch
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state;
  logic [CW-1:0]          cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // Strobe for the cycle in which a pending transition is abandoned.
  assign glitch = (state == COUNT) && (s == db);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state  <= STABLE;
      cnt    <= '0;
      db     <= 1'b0;
      chg    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      chg    <= 1'b0;
      case (state)
        STABLE: begin
          if (s != db) begin
            if (DB_CYCLES == 1) begin
              db  <= s;
              chg <= 1'b1;
            end else begin
              state <= COUNT;
              cnt   <= CW'(1);
            end
          end
        end
        COUNT: begin
          if (s == db) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            db    <= s;
            chg   <= 1'b1;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/and_input_debouncer.sv
// Two-channel synchronizer/debouncer feeding an AND gate; AND_INPUT_DEBOUNCER_GLITCH_CNT_EN adds GLITCH_CNT.
// Latency: A_DB/B_DB and CHG strobes update SYNC_STAGES+DB_CYCLES edges after a stable raw change.
// Backpressure: none; both channels sample every cycle and never stall.
module and_input_debouncer
  import and_gate_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int GLITCH_W    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                A_RAW,
  input  logic                B_RAW,
  output logic                A_DB,
  output logic                B_DB,
  output logic                A_CHG,
  output logic                B_CHG
`ifdef AND_INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] GLITCH_CNT
`endif
);

  logic a_glitch;
  logic b_glitch;

  db_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_chan_a (
    .clk   (CLK),
    .rst   (RST),
    .raw   (A_RAW),
    .db    (A_DB),
    .chg   (A_CHG),
    .glitch(a_glitch)
  );

  db_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_chan_b (
    .clk   (CLK),
    .rst   (RST),
    .raw   (B_RAW),
    .db    (B_DB),
    .chg   (B_CHG),
    .glitch(b_glitch)
  );

`ifdef AND_INPUT_DEBOUNCER_GLITCH_CNT_EN
  localparam int SW = GLITCH_W + 1;

  logic [1:0]    glitch_inc;
  logic [SW-1:0] glitch_sum;

  // One extra sum bit catches overflow, including a +2 step from all-ones minus 1.
  assign glitch_inc = {1'b0, a_glitch} + {1'b0, b_glitch};
  assign glitch_sum = {1'b0, GLITCH_CNT} + SW'(glitch_inc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      GLITCH_CNT <= '0;
    end else if (glitch_sum[GLITCH_W]) begin
      GLITCH_CNT <= '1;
    end else begin
      GLITCH_CNT <= glitch_sum[GLITCH_W-1:0];
    end
  end
`else
  logic [GLITCH_W:0] glitch_unused;
  assign glitch_unused = {GLITCH_W'(a_glitch), b_glitch};
`endif

endmodule
